vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, hsync pulse width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, 480, active lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Port clk_100MHz  input  1  the single system clock; all logic is on its rising edge.
REQ-010 Port rst_n  input  1  reset, synchronous and active-low.
REQ-011 Port pix_en  input  1  pixel-rate enable, one clk_100MHz cycle wide (nominally 1 in 4).
REQ-012 Port hsync  output  1  horizontal sync, active-low.
REQ-013 Port vsync  output  1  vertical sync, active-low.
REQ-014 Port video_on  output  1  high while the current pixel is inside the visible area.
REQ-015 Port pixel_x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-016 Port pixel_y  output  10  current vertical count, 0..V_TOTAL-1.
REQ-017 Port line_end  output  1  one-cycle pulse when a line wraps.
REQ-018 Port frame_start  output  1  one-cycle pulse when the frame wraps to (0,0).

Function
REQ-019 The block SHALL derive H_TOTAL = sum of the H parameters (800) and V_TOTAL = sum of the V parameters (525).
REQ-020 The block SHALL change state only on clock edges where pix_en=1; with pix_en=0, all outputs hold, and both pulse outputs drop to 0 after one cycle.
REQ-021 On a pix_en edge, pixel_x SHALL increment, or wrap from H_TOTAL-1 to 0; pixel_y SHALL increment only on that wrap, and wraps from V_TOTAL-1 to 0.
REQ-022 A horizontal phase FSM SHALL track the states VISIBLE→FRONT→SYNC→BACK→VISIBLE; each transition occurs on the pix_en edge that moves pixel_x to 640, 656, 752 or 0 respectively.
REQ-023 A vertical phase FSM SHALL use the same states, with transitions on the line wraps that move pixel_y to 480, 490, 492 or 0.
REQ-024 hsync, vsync and video_on SHALL be registered and updated on the same edge as the counters, so they describe the new pixel_x/pixel_y with zero relative skew.
REQ-025 hsync SHALL be 0 exactly when pixel_x is in 656..751; vsync SHALL be 0 exactly when pixel_y is in 490..491.
REQ-026 video_on SHALL be 1 exactly when both FSMs are in VISIBLE (pixel_x<640 and pixel_y<480).
REQ-027 line_end SHALL be 1 for exactly the one clock cycle following the edge where pixel_x wraps to 0.
REQ-028 frame_start SHALL be 1 for exactly the one clock cycle following the edge where both counters wrap to (0,0); on that cycle, line_end is also 1.
REQ-029 If pix_en is held high continuously, the block SHALL advance one pixel per clock with the same sequence.
REQ-030 All widths SHALL be 10 bits, and counter compares are unsigned.

Reset
REQ-031 While rst_n=0 on a clock edge, the block SHALL set pixel_x=0, pixel_y=0, both FSMs=VISIBLE, hsync=1, vsync=1, video_on=0, line_end=0 and frame_start=0; rst_n has priority over pix_en.
REQ-032 Pixel (0,0) after reset SHALL be blanked (video_on=0); the first pix_en edge gives (1,0) with video_on=1, and frame_start is not asserted on reset exit.
REQ-033 Reset asserted mid-frame SHALL restart from the REQ-031 state on the next edge, with no partial sync pulse retained.

Structure
REQ-034 The default timing constants and the phase state encoding (2 bits: VISIBLE, FRONT, SYNC, BACK) SHALL live in the shared package vga_timing_pkg.
REQ-035 One sub-module, vga_axis_counter, SHALL hold a counter, its phase FSM and its sync decode; it is instantiated once for horizontal (advance=pix_en) and once for vertical (advance=pix_en AND horizontal wrap).

Verification
REQ-036 Reset, then pix_en every 4th cycle for 800 pulses -> hsync low for exactly 96 pulses starting at pixel_x=656, then line_end high 1 cycle with pixel_y=1.
REQ-037 Run 420000 pix_en pulses from reset -> pixel_x=0, pixel_y=0, frame_start high for 1 cycle, and vsync low only during pixel_y 490..491.
REQ-038 Sweep one full frame -> video_on high for exactly 307200 pix_en edges (minus 1 for the first frame after reset).
REQ-039 pix_en held high for 1600 cycles -> pixel_x covers 0..799 twice and pixel_y reaches 2.
REQ-040 Assert rst_n=0 at pixel_x=700, pixel_y=491 -> on the next edge, all outputs equal the REQ-031 values and hsync/vsync return to 1.
REQ-041 Hold pix_en=0 for 50 cycles mid-line -> all outputs are stable and there are no pulses.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and the shared phase encoding
package vga_timing_pkg;
   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;
   typedef enum logic [1:0] {PH_VISIBLE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;
   function automatic int axis_total(int vis, int front, int sync, int back);
      return vis + front + sync + back;
   endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: pixel enable in, raster timing signals out
interface vga_sync_gen_if;
   logic       pix_en;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       line_end;
   logic       frame_start;
   modport master (input pix_en, output hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_start);
   modport slave  (output pix_en, input hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis -- position counter, phase FSM and active-low sync decode
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VIS   = H_VISIBLE_DEF,
   parameter int FRONT = H_FRONT_DEF,
   parameter int SYNC  = H_SYNC_DEF,
   parameter int BACK  = H_BACK_DEF
) (
   input  logic       clk_100MHz,
   input  logic       rst_n,
   input  logic       advance,
   output logic [9:0] count,
   output logic       sync_n,
   output logic       wrap,
   output logic       vis_next
);
   localparam int TOTAL = axis_total(VIS, FRONT, SYNC, BACK);
   phase_t     phase, nxt_phase;
   logic [9:0] nxt_count;
   // next position and phase; the phase steps when the new count reaches a region boundary
   always_comb begin
      wrap      = advance && count == 10'(TOTAL - 1);
      nxt_count = !advance ? count : wrap ? '0 : count + 10'd1;
      nxt_phase = !advance                             ? phase      :
                  nxt_count == 10'(VIS)                ? PH_FRONT   :
                  nxt_count == 10'(VIS + FRONT)        ? PH_SYNC    :
                  nxt_count == 10'(VIS + FRONT + SYNC) ? PH_BACK    :
                  nxt_count == '0                      ? PH_VISIBLE : phase;
      vis_next  = nxt_phase == PH_VISIBLE;
   end
   // counter, phase and sync all move together so sync never lags the count
   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         count  <= '0;
         phase  <= PH_VISIBLE;
         sync_n <= 1'b1;
      end else if (advance) begin
         count  <= nxt_count;
         phase  <= nxt_phase;
         sync_n <= nxt_phase != PH_SYNC;
      end
   end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator built from a horizontal and a vertical axis counter
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic           clk_100MHz,
   input  logic           rst_n,
   vga_sync_gen_if.master vga
);
   logic [9:0] x, y;
   logic       hs_n, vs_n, h_wrap, v_wrap, h_vis, v_vis;
   logic       video_on, line_end, frame_start;
   vga_axis_counter #(.VIS(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)) u_h (
      .clk_100MHz(clk_100MHz), .rst_n(rst_n), .advance(vga.pix_en),
      .count(x), .sync_n(hs_n), .wrap(h_wrap), .vis_next(h_vis)
   );
   vga_axis_counter #(.VIS(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)) u_v (
      .clk_100MHz(clk_100MHz), .rst_n(rst_n), .advance(h_wrap),
      .count(y), .sync_n(vs_n), .wrap(v_wrap), .vis_next(v_vis)
   );
   // video_on tracks the new pixel; (0,0) after reset stays blanked until the first advance
   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         video_on    <= 1'b0;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_end    <= h_wrap;
         frame_start <= v_wrap;
         if (vga.pix_en) video_on <= h_vis && v_vis;
      end
   end
   assign vga.pixel_x     = x;
   assign vga.pixel_y     = y;
   assign vga.hsync       = hs_n;
   assign vga.vsync       = vs_n;
   assign vga.video_on    = video_on;
   assign vga.line_end    = line_end;
   assign vga.frame_start = frame_start;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: default-timing and reduced-timing generators against a raster position model
module tb_vga_sync_gen;
   logic clk_100MHz = 1'b0;
   logic rst_n = 1'b0;
   logic pix_en = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;
   vga_sync_gen_if a_if();
   vga_sync_gen_if b_if();
   assign a_if.pix_en = pix_en;
   assign b_if.pix_en = pix_en;
   vga_sync_gen dut_a (.clk_100MHz(clk_100MHz), .rst_n(rst_n), .vga(a_if));
   vga_sync_gen #(.H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
                  .V_VISIBLE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)) dut_b (
      .clk_100MHz(clk_100MHz), .rst_n(rst_n), .vga(b_if));
   int hp[2][4] = '{'{640, 16, 96, 48}, '{20, 4, 6, 5}};
   int vp[2][4] = '{'{480, 10, 2, 33}, '{12, 3, 2, 4}};
   int mx[2], my[2];
   bit mvid[2], mle[2], mfs[2];
   int total = 0, bad = 0;
   logic [24:0] got[2];
   localparam logic [24:0] RST_VEC = 25'h1800000;
   assign got[0] = {a_if.hsync, a_if.vsync, a_if.video_on, a_if.pixel_x, a_if.pixel_y, a_if.line_end, a_if.frame_start};
   assign got[1] = {b_if.hsync, b_if.vsync, b_if.video_on, b_if.pixel_x, b_if.pixel_y, b_if.line_end, b_if.frame_start};

   function automatic int htot(int d);
      return hp[d][0] + hp[d][1] + hp[d][2] + hp[d][3];
   endfunction
   function automatic int vtot(int d);
      return vp[d][0] + vp[d][1] + vp[d][2] + vp[d][3];
   endfunction
   function automatic logic [24:0] want(int d);
      int hs0 = hp[d][0] + hp[d][1];
      int vs0 = vp[d][0] + vp[d][1];
      bit hs = !(mx[d] >= hs0 && mx[d] < hs0 + hp[d][2]);
      bit vs = !(my[d] >= vs0 && my[d] < vs0 + vp[d][2]);
      return {hs, vs, mvid[d], 10'(mx[d]), 10'(my[d]), mle[d], mfs[d]};
   endfunction

   task automatic tick(input bit pe, input bit rn);
      pix_en = pe;
      rst_n  = rn;
      @(posedge clk_100MHz);
      for (int d = 0; d < 2; d++) begin
         if (!rn) begin
            mx[d] = 0; my[d] = 0; mvid[d] = 0; mle[d] = 0; mfs[d] = 0;
         end else begin
            mle[d] = 0;
            mfs[d] = 0;
            if (pe) begin
               if (mx[d] == htot(d) - 1) begin
                  mx[d]  = 0;
                  mle[d] = 1;
                  if (my[d] == vtot(d) - 1) begin
                     my[d]  = 0;
                     mfs[d] = 1;
                  end else my[d]++;
               end else mx[d]++;
               mvid[d] = mx[d] < hp[d][0] && my[d] < vp[d][0];
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      tick(0, 0);
      tick(1, 0);
      for (int d = 0; d < 2; d++) begin
         total++;
         if (got[d] !== RST_VEC) begin bad++; $display("FAIL reset_state d%0d got=%h want=%h", d, got[d], RST_VEC); end
      end
      tick(1, 1);
      total++;
      if ({a_if.pixel_x, a_if.video_on, a_if.frame_start} !== {10'd1, 1'b1, 1'b0}) begin
         bad++; $display("FAIL reset_exit got x=%0d vid=%b fs=%b want x=1 vid=1 fs=0", a_if.pixel_x, a_if.video_on, a_if.frame_start);
      end
      for (int d = 0; d < 2; d++) begin
         total++;
         if (got[d] !== want(d)) begin bad++; $display("FAIL reset_exit_model d%0d got=%h want=%h", d, got[d], want(d)); end
      end
   endtask

   task automatic test_line();
      int lows = 0, first = -1;
      tick(0, 0);
      for (int p = 0; p < 800; p++) begin
         for (int c = 0; c < 4; c++) begin
            tick(c == 3, 1);
            for (int d = 0; d < 2; d++) begin
               total++;
               if (got[d] !== want(d)) begin bad++; $display("FAIL line d%0d p=%0d got=%h want=%h", d, p, got[d], want(d)); end
            end
            if (c == 3 && a_if.hsync === 1'b0) begin
               lows++;
               if (first < 0) first = int'(a_if.pixel_x);
            end
         end
      end
      total++;
      if (lows != 96 || first != 656) begin bad++; $display("FAIL hsync_width got lows=%0d first=%0d want 96 656", lows, first); end
      total++;
      if ({a_if.line_end, a_if.pixel_y, a_if.pixel_x} !== {1'b1, 10'd1, 10'd0}) begin
         bad++; $display("FAIL line_wrap got le=%b y=%0d x=%0d want le=1 y=1 x=0", a_if.line_end, a_if.pixel_y, a_if.pixel_x);
      end
      tick(0, 1);
      total++;
      if (a_if.line_end !== 1'b0) begin bad++; $display("FAIL line_end_width got=%b want=0", a_if.line_end); end
   endtask

   task automatic test_hold();
      logic [24:0] snap;
      tick(0, 0);
      repeat ($urandom_range(100, 600)) tick(1, 1);
      snap = got[0];
      for (int c = 0; c < 50; c++) begin
         tick(0, 1);
         total++;
         if (got[0] !== {snap[24:2], 2'b00}) begin bad++; $display("FAIL hold c=%0d got=%h want=%h", c, got[0], {snap[24:2], 2'b00}); end
         for (int d = 0; d < 2; d++) begin
            total++;
            if (got[d] !== want(d)) begin bad++; $display("FAIL hold_model d%0d got=%h want=%h", d, got[d], want(d)); end
         end
      end
   endtask

   task automatic test_continuous();
      int seen[800];
      int off = 0;
      foreach (seen[i]) seen[i] = 0;
      tick(0, 0);
      for (int c = 0; c < 1600; c++) begin
         tick(1, 1);
         seen[a_if.pixel_x]++;
         for (int d = 0; d < 2; d++) begin
            total++;
            if (got[d] !== want(d)) begin bad++; $display("FAIL continuous d%0d c=%0d got=%h want=%h", d, c, got[d], want(d)); end
         end
      end
      foreach (seen[i]) if (seen[i] != 2) off++;
      total++;
      if (off != 0 || a_if.pixel_y !== 10'd2) begin bad++; $display("FAIL continuous_cover got off=%0d y=%0d want 0 2", off, a_if.pixel_y); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         tick($urandom_range(0, 2) == 0, $urandom_range(0, 299) != 0);
         for (int d = 0; d < 2; d++) begin
            total++;
            if (got[d] !== want(d)) begin bad++; $display("FAIL random d%0d c=%0d got=%h want=%h", d, c, got[d], want(d)); end
         end
      end
   endtask

   task automatic test_frame();
      int ft = htot(1) * vtot(1);
      int vis_area = hp[1][0] * vp[1][0];
      int vs0 = vp[1][0] + vp[1][1];
      int vis, vbad;
      tick(0, 0);
      for (int f = 0; f < 2; f++) begin
         vis = 0;
         vbad = 0;
         for (int p = 0; p < ft; p++) begin
            repeat ($urandom_range(0, 3)) tick(0, 1);
            if (b_if.video_on === 1'b1) vis++;
            tick(1, 1);
            if ((b_if.vsync === 1'b0) != (int'(b_if.pixel_y) >= vs0 && int'(b_if.pixel_y) < vs0 + vp[1][2])) vbad++;
            for (int d = 0; d < 2; d++) begin
               total++;
               if (got[d] !== want(d)) begin bad++; $display("FAIL frame d%0d p=%0d got=%h want=%h", d, p, got[d], want(d)); end
            end
         end
         total++;
         if (vis != vis_area - (f == 0 ? 1 : 0) || vbad != 0) begin
            bad++; $display("FAIL frame_video f=%0d got vis=%0d vbad=%0d want vis=%0d vbad=0", f, vis, vbad, vis_area - (f == 0 ? 1 : 0));
         end
         total++;
         if ({b_if.pixel_x, b_if.pixel_y, b_if.line_end, b_if.frame_start} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL frame_wrap got x=%0d y=%0d le=%b fs=%b want 0 0 1 1", b_if.pixel_x, b_if.pixel_y, b_if.line_end, b_if.frame_start);
         end
         tick(0, 1);
         total++;
         if (b_if.frame_start !== 1'b0) begin bad++; $display("FAIL frame_start_width got=%b want=0", b_if.frame_start); end
      end
   endtask

   task automatic test_mid_reset();
      int steps = (vp[1][0] + vp[1][1] + 1) * htot(1) + hp[1][0] + hp[1][1] + 2;
      tick(0, 0);
      repeat (steps) tick(1, 1);
      total++;
      if ({b_if.hsync, b_if.vsync} !== 2'b00) begin bad++; $display("FAIL mid_pulse got hs=%b vs=%b want 0 0", b_if.hsync, b_if.vsync); end
      tick(1, 0);
      for (int d = 0; d < 2; d++) begin
         total++;
         if (got[d] !== RST_VEC) begin bad++; $display("FAIL mid_reset d%0d got=%h want=%h", d, got[d], RST_VEC); end
      end
      tick(1, 1);
      for (int d = 0; d < 2; d++) begin
         total++;
         if (got[d] !== want(d)) begin bad++; $display("FAIL mid_reset_exit d%0d got=%h want=%h", d, got[d], want(d)); end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_hold();
      test_continuous();
      test_random();
      test_frame();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
